cardinal_nic: RTL
=================

Name: cardinal_nic

Overview:
Network interface between one processing element (PE) and the local port of its mesh router.
- Exposes a 4-entry memory-mapped register file to the PE:
  - input-channel buffer and its status,
  - output-channel buffer and its status.
- Runs the router-side send/ready handshakes, including the shared polarity (virtual-channel) rule on injection.
- Instantiated once per mesh node, directly beside the router's pesi/peri/pedi and peso/pero/pedo ports.

Parameters:
PACKET_SIZE, 64, packet and PE data width in bits
VC_BIT, 63, index of the packet's virtual-channel bit

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
addr  in  2  PE register select: 00 in-buf, 01 in-status, 10 out-buf, 11 out-status
d_in  in  PACKET_SIZE  PE write data
d_out  out  PACKET_SIZE  PE read data (combinational)
nicEn  in  1  PE access enable
nicEnWr  in  1  1 = write, 0 = read; qualified by nicEn
net_si  in  1  router has a packet for PE (router peso)
net_ri  out  1  NIC can accept a packet (router pero)
net_di  in  PACKET_SIZE  packet from router (router pedo)
net_so  out  1  NIC injects a packet (router pesi)
net_ro  in  1  router can accept (router peri)
net_do  out  PACKET_SIZE  packet to router (router pedi)
net_polarity  in  1  router polarity (shared toggling register)

Behaviour:
- Reset (async, active-high):
  - ibuf=0, istat=0, obuf=0, ostat=0.
  - net_so=0, net_ri=0 and d_out=0 while reset is high.
- Input channel:
  - net_ri = ~istat when reset is low.
  - On a clock edge with net_si & net_ri: ibuf<=net_di, istat<=1.
  - While istat=1, router packets are not accepted.
- PE read, when nicEn=1 and nicEnWr=0:
  - addr 00: d_out=ibuf; istat<=0 at the edge. Reading while istat=0 returns stale ibuf and leaves istat unchanged.
  - addr 01: d_out={zeros,istat}.
  - addr 10: d_out=obuf.
  - addr 11: d_out={zeros,ostat}.
  - nicEn=0: d_out=0.
- PE write, when nicEn=1 and nicEnWr=1:
  - addr 10 with ostat=0: obuf<=d_in, ostat<=1.
  - addr 10 with ostat=1: write dropped; obuf and ostat unchanged.
  - Writes to 00, 01, 11: ignored.
- Output channel:
  - net_do = obuf at all times.
  - net_so = ostat & net_ro & (obuf[VC_BIT] == net_polarity), combinational.
  - On an edge with net_so=1: ostat<=0.
  - A packet whose VC does not match waits at most one cycle for polarity to flip, provided net_ro stays high.
- Latency:
  - PE write to earliest net_so: 1 cycle.
  - Router accept to istat visible: 1 cycle.
- Simultaneous events:
  - Write to addr 10 in the same cycle ostat clears: write is dropped, because ostat was still 1 at evaluation. The PE must poll addr 11.
  - Accept and read-clear cannot collide, because net_ri=0 while istat=1. The next packet is accepted no earlier than the cycle after the clear.
- Reset mid-transfer: a held packet is discarded and net_so drops immediately.

Optional Feature:
Macro NIC_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit), registered.
  - irq<=1 on the edge where istat rises; irq<=0 on a read of addr 00 or on reset.
  - A read of addr 01 returns {zeros,irq,istat}.
- Undefined: no irq port; addr 01 returns {zeros,istat}.

Decomposition:
- Package nic_pkg:
  - Address constants: ADDR_IBUF=2'b00, ADDR_ISTAT=2'b01, ADDR_OBUF=2'b10, ADDR_OSTAT=2'b11.
  - Default PACKET_SIZE and VC_BIT.
- One sub-module: nic_chan_buf, a single-entry buffer with full flag, load strobe and clear strobe. Instantiated twice (input and output channel). Handshake and polarity logic stays in the top.

Test Plan:
1. Reset asserted mid-cycle → net_so=0, net_ri=0, d_out=0 asynchronously. After release: net_ri=1; reads of 01 and 11 return 0.
2. Write 64'h8000_0000_0000_00A5 to addr 10 with net_ro=1:
   - If net_polarity=1, net_so=1 on the next cycle with net_do equal to that value.
   - Then read 11 → 0.
3. Same write with net_polarity=0 → net_so stays 0 for one cycle, asserts when polarity toggles, then ostat clears.
4. Second write to 10 (value 64'h1) while ostat=1 and net_ro=0 → obuf keeps the first value; read 10 confirms.
5. Router sends 64'h0123_4567_89AB_CDEF with net_si=1:
   - istat=1 and net_ri=0 on the next cycle.
   - A second router packet is held off.
   - Read 00 → d_out=64'h0123_4567_89AB_CDEF; istat=0 and net_ri=1 on the following cycle.
6. With NIC_IRQ_EN: packet arrival → irq=1 and read 01 → 64'h3; read 00 → irq=0 next cycle.

Source files
------------

// File: rtl/nic_pkg.sv
// Shared constants for the cardinal NIC: PE register map and default packet geometry.
package nic_pkg;

    localparam int PACKET_SIZE_DEF = 64;
    localparam int VC_BIT_DEF      = 63;

    localparam logic [1:0] ADDR_IBUF  = 2'b00;
    localparam logic [1:0] ADDR_ISTAT = 2'b01;
    localparam logic [1:0] ADDR_OBUF  = 2'b10;
    localparam logic [1:0] ADDR_OSTAT = 2'b11;

endpackage

// File: rtl/cardinal_nic_if.sv
// PE register bus plus router local-port signals seen by the cardinal NIC.
interface cardinal_nic_if #(
    parameter int PACKET_SIZE = nic_pkg::PACKET_SIZE_DEF
);
    logic [1:0]             addr;
    logic [PACKET_SIZE-1:0] d_in;
    logic [PACKET_SIZE-1:0] d_out;
    logic                   nicEn;
    logic                   nicEnWr;
    logic                   net_si;
    logic                   net_ri;
    logic [PACKET_SIZE-1:0] net_di;
    logic                   net_so;
    logic                   net_ro;
    logic [PACKET_SIZE-1:0] net_do;
    logic                   net_polarity;

    // The NIC is the slave of the PE bus and the peer of the router port.
    modport slave (
        input  addr, d_in, nicEn, nicEnWr,
        input  net_si, net_di, net_ro, net_polarity,
        output d_out, net_ri, net_so, net_do
    );

    modport master (
        output addr, d_in, nicEn, nicEnWr,
        output net_si, net_di, net_ro, net_polarity,
        input  d_out, net_ri, net_so, net_do
    );
endinterface

// File: rtl/nic_chan_buf.sv
// Single-entry channel buffer with full flag; load wins over clear if both strobe.
module nic_chan_buf #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic [W-1:0] data,
    output logic         full
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= '0;
            full <= 1'b0;
        end else if (load) begin
            data <= din;
            full <= 1'b1;
        end else if (clr) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/cardinal_nic.sv
// Cardinal NIC: PE register file and router local-port handshakes.
// Optional NIC_IRQ_EN adds a registered packet-arrival interrupt output irq.
module cardinal_nic
    import nic_pkg::*;
#(
    parameter int PACKET_SIZE = PACKET_SIZE_DEF,
    parameter int VC_BIT      = VC_BIT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    cardinal_nic_if.slave   bus
`ifdef NIC_IRQ_EN
    ,
    output logic            irq
`endif
);

    logic [PACKET_SIZE-1:0] ibuf;
    logic [PACKET_SIZE-1:0] obuf;
    logic                   istat;
    logic                   ostat;
    logic                   pe_rd;
    logic                   pe_wr;
    logic                   in_load;
    logic                   in_clr;
    logic                   out_load;
    logic                   out_clr;
    logic                   vc_match;
    logic [PACKET_SIZE-1:0] d_out_c;

    assign pe_rd = bus.nicEn & ~bus.nicEnWr;
    assign pe_wr = bus.nicEn &  bus.nicEnWr;

    // Router side: accept only into an empty input buffer, inject only on matching VC.
    assign bus.net_ri = ~reset & ~istat;
    assign vc_match   = (obuf[VC_BIT] == bus.net_polarity);
    assign bus.net_so = ~reset & ostat & bus.net_ro & vc_match;
    assign bus.net_do = obuf;

    assign in_load  = bus.net_si & bus.net_ri;
    assign in_clr   = pe_rd & (bus.addr == ADDR_IBUF);
    // A write racing the injection edge sees ostat=1 and is dropped.
    assign out_load = pe_wr & (bus.addr == ADDR_OBUF) & ~ostat;
    assign out_clr  = bus.net_so;

    nic_chan_buf #(.W(PACKET_SIZE)) u_in_buf (
        .clk   (clk),
        .reset (reset),
        .load  (in_load),
        .clr   (in_clr),
        .din   (bus.net_di),
        .data  (ibuf),
        .full  (istat)
    );

    nic_chan_buf #(.W(PACKET_SIZE)) u_out_buf (
        .clk   (clk),
        .reset (reset),
        .load  (out_load),
        .clr   (out_clr),
        .din   (bus.d_in),
        .data  (obuf),
        .full  (ostat)
    );

`ifdef NIC_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else if (in_load) begin
            irq <= 1'b1;
        end else if (in_clr) begin
            irq <= 1'b0;
        end
    end
`endif

    always_comb begin
        d_out_c = '0;
        if (!reset && pe_rd) begin
            case (bus.addr)
                ADDR_IBUF:  d_out_c = ibuf;
`ifdef NIC_IRQ_EN
                ADDR_ISTAT: d_out_c = PACKET_SIZE'({irq, istat});
`else
                ADDR_ISTAT: d_out_c = PACKET_SIZE'(istat);
`endif
                ADDR_OBUF:  d_out_c = obuf;
                default:    d_out_c = PACKET_SIZE'(ostat);
            endcase
        end
    end

    assign bus.d_out = d_out_c;

endmodule
